// File: rtl/drive_cmd_sequencer_if.sv
// Move-queue push channel between a producer (software/planner) and the
// drive command sequencer.
interface drive_cmd_sequencer_if;
  logic        push_valid;
  logic        push_ready;
  logic [2:0]  push_cmd;
  logic [7:0]  push_speed;
  logic [15:0] push_dur;

  modport master (
    output push_valid,
    output push_cmd,
    output push_speed,
    output push_dur,
    input  push_ready
  );

  modport slave (
    input  push_valid,
    input  push_cmd,
    input  push_speed,
    input  push_dur,
    output push_ready
  );
endinterface

// File: rtl/drive_cmd_sequencer.sv
// Plays back a queue of timed moves as cmd/base_speed for the drive system,
// handing U-turns off to the drive timer through robot_busy.
module drive_cmd_sequencer #(
  parameter int FIFO_DEPTH     = 8,
  parameter int TICKS_PER_UNIT = 50000,
  parameter int SETTLE_TICKS   = 1000,
  parameter int BUSY_TIMEOUT   = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  drive_cmd_sequencer_if.slave          push,
  input  logic                          start,
  input  logic                          abort,
  input  logic                          robot_busy,
  output logic [2:0]                    cmd,
  output logic [7:0]                    base_speed,
  output logic                          seq_active,
  output logic                          seq_done,
  output logic                          err_cmd,
  output logic                          err_busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int PW = (TICKS_PER_UNIT > 1) ? $clog2(TICKS_PER_UNIT) : 1;
  localparam int SW = (SETTLE_TICKS > 1) ? $clog2(SETTLE_TICKS) : 1;
  localparam int TW = (BUSY_TIMEOUT > 1) ? $clog2(BUSY_TIMEOUT) : 1;

  localparam logic [2:0] C_STOP  = 3'd0;
  localparam logic [2:0] C_UTURN = 3'd4;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RUN,
    S_UT_ISSUE,
    S_UT_WAIT,
    S_SETTLE,
    S_ABORTING
  } state_e;

  state_e state_q, state_d;

  logic [2:0]  mem_cmd [FIFO_DEPTH];
  logic [7:0]  mem_spd [FIFO_DEPTH];
  logic [15:0] mem_dur [FIFO_DEPTH];

  logic [AW-1:0] wr_q, wr_d;
  logic [AW-1:0] rd_q, rd_d;
  logic [CW-1:0] count_q, count_d;

  logic [2:0]    cmd_q, cmd_d;
  logic [7:0]    spd_q, spd_d;
  logic [15:0]   unit_q, unit_d;
  logic [PW-1:0] pre_q, pre_d;
  logic [SW-1:0] set_q, set_d;
  logic [TW-1:0] to_q, to_d;
  logic          done_q, done_d;
  logic          errc_q, errc_d;
  logic          errb_q, errb_d;
  logic          act_q, act_d;

  logic          full;
  logic          push_fire;
  logic          wr_en;
  logic          pop;
  logic          flush;
  logic          take;
  logic          go_settle;
  logic [2:0]    h_cmd;
  logic [7:0]    h_spd;
  logic [15:0]   h_dur;

  assign full            = (count_q == CW'(FIFO_DEPTH));
  assign push.push_ready = !full;

  // abort wins over any push in the same cycle
  assign push_fire = push.push_valid && !full && !abort;
  assign wr_en     = push_fire && (push.push_cmd <= C_UTURN);
  assign errc_d    = push_fire && (push.push_cmd > C_UTURN);

  assign h_cmd = mem_cmd[rd_q];
  assign h_spd = mem_spd[rd_q];
  assign h_dur = mem_dur[rd_q];

  always_comb begin
    state_d   = state_q;
    cmd_d     = cmd_q;
    spd_d     = spd_q;
    unit_d    = unit_q;
    pre_d     = pre_q;
    set_d     = set_q;
    to_d      = to_q;
    done_d    = 1'b0;
    errb_d    = errb_q;
    flush     = 1'b0;
    take      = 1'b0;
    go_settle = 1'b0;

    if (abort && state_q != S_IDLE) begin
      flush   = 1'b1;
      state_d = S_ABORTING;
      cmd_d   = C_STOP;
      spd_d   = 8'd0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (abort) begin
            flush = 1'b1;
          end else if (start && count_q != '0) begin
            take   = 1'b1;
            errb_d = 1'b0;
          end
        end
        S_RUN: begin
          if (pre_q == PW'(TICKS_PER_UNIT - 1)) begin
            pre_d  = '0;
            unit_d = unit_q - 16'd1;
            if (unit_q == 16'd1) go_settle = 1'b1;
          end else begin
            pre_d = pre_q + PW'(1);
          end
        end
        S_UT_ISSUE: begin
          if (robot_busy) begin
            state_d = S_UT_WAIT;
            cmd_d   = C_STOP;
            spd_d   = 8'd0;
          end else if (to_q == TW'(BUSY_TIMEOUT - 1)) begin
            errb_d    = 1'b1;
            go_settle = 1'b1;
          end else begin
            to_d = to_q + TW'(1);
          end
        end
        S_UT_WAIT: begin
          if (!robot_busy) go_settle = 1'b1;
        end
        S_SETTLE: begin
          if (set_q == SW'(SETTLE_TICKS - 1)) begin
            if (count_q != '0) begin
              take = 1'b1;
            end else begin
              done_d  = 1'b1;
              state_d = S_IDLE;
            end
          end else begin
            set_d = set_q + SW'(1);
          end
        end
        S_ABORTING: begin
          if (!robot_busy) state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end

    if (go_settle) begin
      state_d = S_SETTLE;
      cmd_d   = C_STOP;
      spd_d   = 8'd0;
      set_d   = '0;
    end

    if (take) begin
      pre_d  = '0;
      unit_d = h_dur;
      to_d   = '0;
      if (h_cmd == C_UTURN) begin
        state_d = S_UT_ISSUE;
        cmd_d   = C_UTURN;
        spd_d   = h_spd;
      end else if (h_dur == 16'd0) begin
        state_d = S_SETTLE;
        cmd_d   = C_STOP;
        spd_d   = 8'd0;
        set_d   = '0;
      end else begin
        state_d = S_RUN;
        cmd_d   = h_cmd;
        spd_d   = (h_cmd == C_STOP) ? 8'd0 : h_spd;
      end
    end

    act_d = (state_d != S_IDLE);
  end

  assign pop = take;

  always_comb begin
    wr_d    = wr_q;
    rd_d    = rd_q;
    count_d = count_q;
    if (flush) begin
      rd_d    = wr_q;
      count_d = '0;
    end else begin
      if (wr_en) wr_d = wr_q + AW'(1);
      if (pop)   rd_d = rd_q + AW'(1);
      count_d = count_q + CW'(wr_en) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_cmd[wr_q] <= push.push_cmd;
      mem_spd[wr_q] <= push.push_speed;
      mem_dur[wr_q] <= push.push_dur;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
      cmd_q   <= C_STOP;
      spd_q   <= 8'd0;
      unit_q  <= 16'd0;
      pre_q   <= '0;
      set_q   <= '0;
      to_q    <= '0;
      done_q  <= 1'b0;
      errc_q  <= 1'b0;
      errb_q  <= 1'b0;
      act_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      count_q <= count_d;
      cmd_q   <= cmd_d;
      spd_q   <= spd_d;
      unit_q  <= unit_d;
      pre_q   <= pre_d;
      set_q   <= set_d;
      to_q    <= to_d;
      done_q  <= done_d;
      errc_q  <= errc_d;
      errb_q  <= errb_d;
      act_q   <= act_d;
    end
  end

  assign cmd        = cmd_q;
  assign base_speed = spd_q;
  assign seq_active = act_q;
  assign seq_done   = done_q;
  assign err_cmd    = errc_q;
  assign err_busy   = errb_q;
  assign fifo_count = count_q;

endmodule

// File: tb/tb_drive_cmd_sequencer.sv
// Directed bench for drive_cmd_sequencer with a small behavioural
// drive system that holds robot_busy for 10 cycles per U-turn.
module tb_drive_cmd_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       abort;
  logic       robot_busy;
  logic [2:0] cmd;
  logic [7:0] base_speed;
  logic       seq_active;
  logic       seq_done;
  logic       err_cmd;
  logic       err_busy;
  logic [2:0] fifo_count;

  int total = 0;
  int passed = 0;

  drive_cmd_sequencer_if pif ();

  drive_cmd_sequencer #(
    .FIFO_DEPTH    (4),
    .TICKS_PER_UNIT(4),
    .SETTLE_TICKS  (3),
    .BUSY_TIMEOUT  (4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .push      (pif.slave),
    .start     (start),
    .abort     (abort),
    .robot_busy(robot_busy),
    .cmd       (cmd),
    .base_speed(base_speed),
    .seq_active(seq_active),
    .seq_done  (seq_done),
    .err_cmd   (err_cmd),
    .err_busy  (err_busy),
    .fifo_count(fifo_count)
  );

  always #5 clk = ~clk;

  logic busy_m;
  logic tie_low = 1'b0;
  int   ut_cnt;
  int   busy_rises = 0;

  always @(posedge clk) begin
    if (rst) begin
      busy_m <= 1'b0;
      ut_cnt <= 0;
    end else if (busy_m) begin
      if (ut_cnt == 9) busy_m <= 1'b0;
      else ut_cnt <= ut_cnt + 1;
    end else if (cmd == 3'd4 && !tie_low) begin
      busy_m     <= 1'b1;
      ut_cnt     <= 0;
      busy_rises <= busy_rises + 1;
    end
  end

  assign robot_busy = tie_low ? 1'b0 : busy_m;

  task automatic do_push(input logic [2:0] c, input logic [7:0] s,
                         input logic [15:0] d);
    pif.push_valid = 1'b1;
    pif.push_cmd   = c;
    pif.push_speed = s;
    pif.push_dur   = d;
    @(negedge clk);
    pif.push_valid = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic count_run(input logic [2:0] c, input logic [7:0] s,
                           input logic act, output int n);
    n = 0;
    while (cmd === c && base_speed === s && seq_active === act && n < 300) begin
      n++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    total++;
    if (cmd !== 3'd0 || base_speed !== 8'd0 || seq_active !== 1'b0 ||
        seq_done !== 1'b0 || err_cmd !== 1'b0 || err_busy !== 1'b0 ||
        fifo_count !== 3'd0 || pif.push_ready !== 1'b1)
      $display("FAIL reset: cmd=%0d spd=%0d act=%b done=%b ec=%b eb=%b cnt=%0d rdy=%b want all 0, rdy=1",
               cmd, base_speed, seq_active, seq_done, err_cmd, err_busy,
               fifo_count, pif.push_ready);
    else passed++;
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_single_fwd();
    int n;
    do_push(3'd1, 8'd200, 16'd3);
    do_start();
    count_run(3'd1, 8'd200, 1'b1, n);
    total++;
    if (n !== 12) $display("FAIL fwd_len: got %0d want 12", n);
    else passed++;
    count_run(3'd0, 8'd0, 1'b1, n);
    total++;
    if (n !== 3) $display("FAIL fwd_settle: got %0d want 3", n);
    else passed++;
    total++;
    if (seq_done !== 1'b1 || seq_active !== 1'b0 || fifo_count !== 3'd0)
      $display("FAIL fwd_done: done=%b act=%b cnt=%0d want 1 0 0",
               seq_done, seq_active, fifo_count);
    else passed++;
    @(negedge clk);
    total++;
    if (seq_done !== 1'b0) $display("FAIL fwd_done_pulse: got %b want 0", seq_done);
    else passed++;
  endtask

  task automatic test_sequence_uturn();
    int n;
    int r0;
    r0 = busy_rises;
    do_push(3'd2, 8'd80, 16'd1);
    do_push(3'd4, 8'd150, 16'd7);
    do_push(3'd3, 8'd90, 16'd2);
    do_start();
    count_run(3'd2, 8'd80, 1'b1, n);
    total++;
    if (n !== 4) $display("FAIL seq_left: got %0d want 4", n);
    else passed++;
    count_run(3'd0, 8'd0, 1'b1, n);
    total++;
    if (n !== 3) $display("FAIL seq_settle1: got %0d want 3", n);
    else passed++;
    count_run(3'd4, 8'd150, 1'b1, n);
    total++;
    if (n !== 2) $display("FAIL seq_uturn: got %0d want 2", n);
    else passed++;
    count_run(3'd0, 8'd0, 1'b1, n);
    total++;
    if (n !== 13) $display("FAIL seq_ut_stop: got %0d want 13", n);
    else passed++;
    count_run(3'd3, 8'd90, 1'b1, n);
    total++;
    if (n !== 8) $display("FAIL seq_right: got %0d want 8", n);
    else passed++;
    count_run(3'd0, 8'd0, 1'b1, n);
    total++;
    if (n !== 3 || seq_done !== 1'b1)
      $display("FAIL seq_end: settle=%0d done=%b want 3 1", n, seq_done);
    else passed++;
    total++;
    if (busy_rises - r0 !== 1 || err_busy !== 1'b0)
      $display("FAIL seq_busy: rises=%0d eb=%b want 1 0",
               busy_rises - r0, err_busy);
    else passed++;
    @(negedge clk);
  endtask

  task automatic test_busy_timeout();
    int n;
    tie_low = 1'b1;
    do_push(3'd4, 8'd100, 16'd0);
    do_start();
    count_run(3'd4, 8'd100, 1'b1, n);
    total++;
    if (n !== 4 || err_busy !== 1'b1)
      $display("FAIL timeout: cycles=%0d eb=%b want 4 1", n, err_busy);
    else passed++;
    count_run(3'd0, 8'd0, 1'b1, n);
    total++;
    if (n !== 3 || seq_done !== 1'b1)
      $display("FAIL timeout_done: settle=%0d done=%b want 3 1", n, seq_done);
    else passed++;
    tie_low = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_fifo_full_err();
    for (int i = 0; i < 4; i++) do_push(3'd1, 8'(i + 1), 16'd1);
    total++;
    if (pif.push_ready !== 1'b0 || fifo_count !== 3'd4)
      $display("FAIL full: rdy=%b cnt=%0d want 0 4", pif.push_ready, fifo_count);
    else passed++;
    do_push(3'd1, 8'd9, 16'd1);
    total++;
    if (fifo_count !== 3'd4) $display("FAIL full_reject: cnt=%0d want 4", fifo_count);
    else passed++;
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    total++;
    if (fifo_count !== 3'd0 || seq_active !== 1'b0)
      $display("FAIL idle_abort: cnt=%0d act=%b want 0 0", fifo_count, seq_active);
    else passed++;
    do_push(3'd1, 8'd10, 16'd1);
    do_push(3'd6, 8'd10, 16'd1);
    total++;
    if (err_cmd !== 1'b1 || fifo_count !== 3'd1)
      $display("FAIL err_cmd: ec=%b cnt=%0d want 1 1", err_cmd, fifo_count);
    else passed++;
    @(negedge clk);
    total++;
    if (err_cmd !== 1'b0) $display("FAIL err_cmd_pulse: got %b want 0", err_cmd);
    else passed++;
  endtask

  task automatic test_abort_uturn();
    int n;
    int bad;
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    do_push(3'd4, 8'd120, 16'd0);
    do_push(3'd1, 8'd50, 16'd1);
    do_start();
    total++;
    if (err_busy !== 1'b0) $display("FAIL start_clr_eb: got %b want 0", err_busy);
    else passed++;
    count_run(3'd4, 8'd120, 1'b1, n);
    repeat (2) @(negedge clk);
    total++;
    if (robot_busy !== 1'b1 || cmd !== 3'd0)
      $display("FAIL abort_pre: busy=%b cmd=%0d want 1 0", robot_busy, cmd);
    else passed++;
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    total++;
    if (cmd !== 3'd0 || fifo_count !== 3'd0 || seq_active !== 1'b1)
      $display("FAIL abort_now: cmd=%0d cnt=%0d act=%b want 0 0 1",
               cmd, fifo_count, seq_active);
    else passed++;
    bad = 0;
    n = 0;
    while (robot_busy === 1'b1 && n < 50) begin
      if (seq_active !== 1'b1 || seq_done !== 1'b0 || cmd !== 3'd0) bad++;
      n++;
      @(negedge clk);
    end
    total++;
    if (bad !== 0 || n >= 50 || seq_active !== 1'b1)
      $display("FAIL aborting_hold: bad=%0d cycles=%0d act=%b want 0 <50 1",
               bad, n, seq_active);
    else passed++;
    @(negedge clk);
    total++;
    if (seq_active !== 1'b0 || seq_done !== 1'b0)
      $display("FAIL abort_exit: act=%b done=%b want 0 0", seq_active, seq_done);
    else passed++;
  endtask

  task automatic test_reset_mid_run();
    do_push(3'd1, 8'd255, 16'd100);
    do_start();
    repeat (20) @(negedge clk);
    total++;
    if (cmd !== 3'd1 || base_speed !== 8'd255)
      $display("FAIL run_pre_rst: cmd=%0d spd=%0d want 1 255", cmd, base_speed);
    else passed++;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    total++;
    if (cmd !== 3'd0 || base_speed !== 8'd0 || fifo_count !== 3'd0 ||
        seq_active !== 1'b0)
      $display("FAIL rst_mid: cmd=%0d spd=%0d cnt=%0d act=%b want 0 0 0 0",
               cmd, base_speed, fifo_count, seq_active);
    else passed++;
    do_start();
    @(negedge clk);
    total++;
    if (seq_active !== 1'b0 || cmd !== 3'd0)
      $display("FAIL empty_start: act=%b cmd=%0d want 0 0", seq_active, cmd);
    else passed++;
  endtask

  initial begin
    start = 1'b0;
    abort = 1'b0;
    pif.push_valid = 1'b0;
    pif.push_cmd   = 3'd0;
    pif.push_speed = 8'd0;
    pif.push_dur   = 16'd0;
    @(negedge clk);
    test_reset();
    test_single_fwd();
    test_sequence_uturn();
    test_busy_timeout();
    test_fifo_full_err();
    test_abort_uturn();
    test_reset_mid_run();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
